if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the multicycle RISC; sits directly upstream of the RF+ALU datapath and supplies its 16-bit Ins word.
- Owns the PC and issues word-addressed requests to instruction memory through a req/valid handshake.
- Holds one fetched instruction in an IF/ID buffer until the decode side consumes it.
- Redirects on taken branches and discards stale responses.

Parameters:
PC_W, 16, PC / instruction-memory address width
INS_W, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on Reset

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
IMReq  out  1  instruction-memory request
IMAddr  out  PC_W  request address; stable while IMReq=1 and IMValid=0
IMData  in  INS_W  memory read data; valid when IMValid=1
IMValid  in  1  one-cycle response strobe for the outstanding request
Stall  in  1  decode/control not ready; buffer must hold
BranchTaken  in  1  one-cycle redirect pulse
BranchTarget  in  PC_W  redirect address, sampled with BranchTaken
Ins  out  INS_W  buffered instruction to the RF+ALU stage
PC_ID  out  PC_W  address of Ins
InsValid  out  1  Ins holds an unconsumed instruction

Behaviour:
- Reset, synchronous, dominates all inputs:
  - PC<=RESET_PC, state<=S_BOOT, InsValid<=0, Ins<=0, PC_ID<=0, discard<=0.
  - Also applies mid-request: memory is reset by the same Reset, so no response is owed.
- S_BOOT: IMReq=0; next cycle goes to S_FETCH.
- S_FETCH: IMReq=1, IMAddr=PC. Entered only with an empty buffer.
  - On IMValid with discard=0 and BranchTaken=0: Ins<=IMData, PC_ID<=PC, InsValid<=1, PC<=PC+1 (wraps at 2^PC_W), go S_FULL.
  - On IMValid with discard=1: drop data, discard<=0, stay in S_FETCH. The next request issues the following cycle at the already-loaded target PC.
- S_FULL: IMReq=0.
  - Consumption occurs at an edge where InsValid=1 and Stall=0.
  - On consumption: InsValid<=0, go S_FETCH.
  - With Stall=1: Ins, PC_ID and InsValid hold.
- Throughput: at most one instruction per 2 cycles; with zero-wait memory, latency from S_FETCH entry to InsValid is 1 cycle.
- BranchTaken=1, priority over Stall and IMValid, any state except during Reset:
  - PC<=BranchTarget and InsValid<=0; the buffer is flushed even if Stall=1.
  - In S_FETCH with IMValid=0: the request stays asserted with the old IMAddr (address stability rule). Set discard<=1 and stay in S_FETCH. IMAddr switches to the target only after the stale response arrives.
  - In S_FETCH with IMValid=1 in the same cycle: data dropped, discard stays 0, stay in S_FETCH. The new request at the target is issued next cycle.
  - In S_FULL or S_BOOT: go S_FETCH.
- While discard=1, a second BranchTaken overwrites PC only; the single outstanding response is still discarded.
- IMValid outside S_FETCH is a memory-protocol violation; it is ignored, and the bench asserts on it.

Optional Feature:
IF_FETCH_CNT_EN
- Defined: adds output FetchCnt (16 bits), a count of consumed instructions.
  - Reset to 0 by Reset.
  - Increments by 1 on each consumption edge and wraps at 16'hFFFF->0.
  - Flushed instructions are not counted.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (cpu_pkg): PC_W, INS_W, RESET_PC, the fetch state encoding (S_BOOT=2'd0, S_FETCH=2'd1, S_FULL=2'd2), and the NOP instruction constant used by the bench.
- One natural sub-module: if_pc_reg, holding the PC register with reset, increment, branch-load and hold controls.
- The FSM and IF/ID buffer stay in the top module.

Test Plan:
1. Reset, zero-wait memory returning IMData=IMAddr^16'hA5A5, Stall=0 -> IMReq rises 1 cycle after Reset falls; InsValid pulses every 2nd cycle with PC_ID=0,1,2,… and Ins=16'hA5A5,16'hA5A4,…
2. Stall=1 for 5 cycles while InsValid=1 -> Ins and PC_ID unchanged, IMReq=0 throughout; after release exactly one consumption occurs and IMAddr=PC_ID+1.
3. Memory with 3-cycle latency, BranchTaken with BranchTarget=16'h0040 one cycle after the request to 16'h0005 -> IMAddr stays 16'h0005 until IMValid; that data is never presented; the next request is to 16'h0040 and InsValid later shows PC_ID=16'h0040.
4. BranchTaken with BranchTarget=16'h0100 in the same cycle as IMValid -> no InsValid for the old address; the next cycle has IMReq=1, IMAddr=16'h0100.
5. BranchTaken with BranchTarget=16'h0020 while in S_FULL with Stall=1 -> InsValid=0 next cycle; a fetch from 16'h0020 follows.
6. PC at 16'hFFFF; also Reset asserted mid-request -> after the 16'hFFFF fetch, IMAddr wraps to 16'h0000; the Reset case returns to S_BOOT with PC=RESET_PC and InsValid=0. With IF_FETCH_CNT_EN defined, FetchCnt equals the number of consumptions.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the multicycle RISC front end: widths, reset PC,
// fetch FSM state encoding and the NOP instruction word.
package cpu_pkg;

  localparam int PC_W  = 16;
  localparam int INS_W = 16;

  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [INS_W-1:0] INS_NOP = 16'h0000;

  // Sequential PC step; wraps naturally at 2^PC_W.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: synchronous reset, branch load, increment, hold.
// Load has priority over increment.
module if_pc_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else if (load)
      pc <= load_val;
    else if (inc)
      pc <= pc_next(pc);
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory req/valid handshake, one-entry
// IF/ID buffer, branch redirect. Optional consumed-instruction counter: IF_FETCH_CNT_EN.
module if_fetch_stage
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             Reset,
  output logic             IMReq,
  output logic [PC_W-1:0]  IMAddr,
  input  logic [INS_W-1:0] IMData,
  input  logic             IMValid,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [PC_W-1:0]  BranchTarget,
  output logic [INS_W-1:0] Ins,
  output logic [PC_W-1:0]  PC_ID,
  output logic             InsValid
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [15:0]      FetchCnt
`endif
);

  // Handshake: IMReq stays high with a stable IMAddr until the single
  // IMValid strobe for that request; a branch during an outstanding request
  // marks its response for discard instead of moving IMAddr.
  logic [1:0]      state;
  logic            discard;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] stale_addr;
  logic            fetch_ok;
  logic            consume;

  assign IMReq    = (state == S_FETCH);
  assign IMAddr   = discard ? stale_addr : pc;
  assign fetch_ok = (state == S_FETCH) && IMValid && !discard && !BranchTaken;
  assign consume  = (state == S_FULL) && InsValid && !Stall && !BranchTaken;

  if_pc_reg u_pc_reg (
    .clk      (clk),
    .reset    (Reset),
    .inc      (fetch_ok),
    .load     (BranchTaken),
    .load_val (BranchTarget),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= S_BOOT;
      discard    <= 1'b0;
      stale_addr <= RESET_PC;
      Ins        <= INS_NOP;
      PC_ID      <= '0;
      InsValid   <= 1'b0;
    end else begin
      if (BranchTaken)
        InsValid <= 1'b0;
      case (state)
        S_BOOT: state <= S_FETCH;
        S_FETCH: begin
          if (IMValid) begin
            discard <= 1'b0;
            if (fetch_ok) begin
              Ins      <= IMData;
              PC_ID    <= pc;
              InsValid <= 1'b1;
              state    <= S_FULL;
            end
          end else if (BranchTaken && !discard) begin
            // Remember the in-flight address so IMAddr stays put until its response.
            discard    <= 1'b1;
            stale_addr <= pc;
          end
        end
        S_FULL: begin
          if (BranchTaken || consume) begin
            InsValid <= 1'b0;
            state    <= S_FETCH;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (Reset)
      FetchCnt <= '0;
    else if (consume)
      FetchCnt <= FetchCnt + 16'd1;
  end
`endif

endmodule
